// File: rtl/pc_seq_unit_if.sv
// Control/status bundle between the core controller and the PC sequencer.
// The controller side uses the master modport; the sequencer uses slave.
interface pc_seq_unit_if #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

    logic              commit;
    logic              stall;
    logic              if_en;
    logic              br_taken;
    logic [ADDR_W-1:0] br_off;
    logic              jmp_en;
    logic [ADDR_W-1:0] jmp_tgt;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] inst_addr;
    logic [ADDR_W-1:0] pc;
    logic              ras_ovf;
    logic              ras_unf;
    logic [CntW-1:0]   ras_cnt;

    modport master (
        output commit, stall, if_en, br_taken, br_off, jmp_en, jmp_tgt, call, ret,
        input  inst_addr, pc, ras_ovf, ras_unf, ras_cnt
    );

    modport slave (
        input  commit, stall, if_en, br_taken, br_off, jmp_en, jmp_tgt, call, ret,
        output inst_addr, pc, ras_ovf, ras_unf, ras_cnt
    );
endinterface

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: relative branch, absolute jump, call/return through a
// circular return-address stack, and stall. PC advances once per committed instruction.
module pc_seq_unit #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    pc_seq_unit_if.slave bus
);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic              upd;
    logic              push;
    logic [ADDR_W-1:0] pc_inc;
    logic [PtrW-1:0]   ptr_dec;

    assign upd     = bus.commit & ~bus.stall;
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign ptr_dec = ptr_q - PtrW'(1);

    // ret > jmp_en > br_taken > sequential; lower requests are dropped
    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        push  = 1'b0;
        if (upd) begin
            if (bus.ret) begin
                if (cnt_q != '0) begin
                    pc_d  = ras_q[ptr_dec];
                    ptr_d = ptr_dec;
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end
            end else if (bus.jmp_en) begin
                pc_d = bus.jmp_tgt;
                if (bus.call) begin
                    push  = 1'b1;
                    ptr_d = ptr_q + PtrW'(1);
                    // Full stack: the write pointer sits on the oldest entry, so it is overwritten
                    if (cnt_q == CntFull) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end else if (bus.br_taken) begin
                pc_d = pc_inc + bus.br_off;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (push) begin
            ras_q[ptr_q] <= pc_inc;
        end
    end

    assign bus.inst_addr = bus.if_en ? pc_q : '0;
    assign bus.pc        = pc_q;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
    assign bus.ras_cnt   = cnt_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: a table of one-cycle vectors with hand-computed
// results, followed by a hand-written asynchronous-reset sequence.
module tb_pc_seq_unit;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned RAS_DEPTH = 4;

    typedef struct {
        string       name;
        logic        commit;
        logic        stall;
        logic        if_en;
        logic        br_taken;
        logic [15:0] br_off;
        logic        jmp_en;
        logic [15:0] jmp_tgt;
        logic        call;
        logic        ret;
        logic [15:0] exp_pc;
        int          exp_cnt;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    pc_seq_unit_if #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_seq_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_VEC(16'h0010),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic cm, input logic st, input logic ie,
                       input logic br, input logic [15:0] off, input logic jp,
                       input logic [15:0] tgt, input logic cl, input logic rt,
                       input logic [15:0] epc, input int ecnt, input logic eovf,
                       input logic eunf);
        vec_t v;
        v.name = name; v.commit = cm; v.stall = st; v.if_en = ie;
        v.br_taken = br; v.br_off = off; v.jmp_en = jp; v.jmp_tgt = tgt;
        v.call = cl; v.ret = rt; v.exp_pc = epc; v.exp_cnt = ecnt;
        v.exp_ovf = eovf; v.exp_unf = eunf;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        bus.commit = 0; bus.stall = 0; bus.if_en = 0; bus.br_taken = 0; bus.br_off = '0;
        bus.jmp_en = 0; bus.jmp_tgt = '0; bus.call = 0; bus.ret = 0;
    endtask

    task automatic apply(input vec_t v);
        bus.commit = v.commit; bus.stall = v.stall; bus.if_en = v.if_en;
        bus.br_taken = v.br_taken; bus.br_off = v.br_off; bus.jmp_en = v.jmp_en;
        bus.jmp_tgt = v.jmp_tgt; bus.call = v.call; bus.ret = v.ret;
        @(posedge clk);
        #1;
        check({v.name, ".pc"}, 32'(bus.pc), 32'(v.exp_pc));
        check({v.name, ".cnt"}, 32'(bus.ras_cnt), 32'(v.exp_cnt));
        check({v.name, ".ovf"}, 32'(bus.ras_ovf), 32'(v.exp_ovf));
        check({v.name, ".unf"}, 32'(bus.ras_unf), 32'(v.exp_unf));
        check({v.name, ".iaddr"}, 32'(bus.inst_addr), v.if_en ? 32'(v.exp_pc) : 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_idle();

        //   name        cm st ie br off       jp tgt       cl rt  pc        cnt ovf unf
        add("seq1",      1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0011, 0, 0, 0);
        add("seq2",      1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0012, 0, 0, 0);
        add("seq3",      1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0013, 0, 0, 0);
        add("jmp20",     1, 0, 1, 0, 16'h0000, 1, 16'h0020, 0, 0, 16'h0020, 0, 0, 0);
        add("br_neg",    1, 0, 1, 1, 16'hFFFB, 0, 16'h0000, 0, 0, 16'h001C, 0, 0, 0);
        add("jmp20b",    1, 0, 0, 0, 16'h0000, 1, 16'h0020, 0, 0, 16'h0020, 0, 0, 0);
        add("br_stall",  1, 1, 1, 1, 16'hFFFB, 0, 16'h0000, 0, 0, 16'h0020, 0, 0, 0);
        add("no_commit", 0, 0, 1, 1, 16'hFFFB, 1, 16'h0777, 1, 0, 16'h0020, 0, 0, 0);
        add("jmp100",    1, 0, 0, 0, 16'h0000, 1, 16'h0100, 0, 0, 16'h0100, 0, 0, 0);
        add("call400",   1, 0, 1, 0, 16'h0000, 1, 16'h0400, 1, 0, 16'h0400, 1, 0, 0);
        add("ret101",    1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0101, 0, 0, 0);
        add("jmp10",     1, 0, 0, 0, 16'h0000, 1, 16'h0010, 0, 0, 16'h0010, 0, 0, 0);
        add("nest1",     1, 0, 0, 0, 16'h0000, 1, 16'h0020, 1, 0, 16'h0020, 1, 0, 0);
        add("nest2",     1, 0, 0, 0, 16'h0000, 1, 16'h0030, 1, 0, 16'h0030, 2, 0, 0);
        add("nest3",     1, 0, 0, 0, 16'h0000, 1, 16'h0040, 1, 0, 16'h0040, 3, 0, 0);
        add("nest4",     1, 0, 0, 0, 16'h0000, 1, 16'h0050, 1, 0, 16'h0050, 4, 0, 0);
        add("nest5_ovf", 1, 0, 0, 0, 16'h0000, 1, 16'h0060, 1, 0, 16'h0060, 4, 1, 0);
        add("ovf_clear", 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0060, 4, 0, 0);
        add("ret51",     1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0051, 3, 0, 0);
        add("ret41",     1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0041, 2, 0, 0);
        add("ret31",     1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0031, 1, 0, 0);
        add("ret21",     1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0021, 0, 0, 0);
        add("ret_unf",   1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0022, 0, 0, 1);
        add("unf_clear", 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0022, 0, 0, 0);
        add("jmp122",    1, 0, 0, 0, 16'h0000, 1, 16'h0122, 0, 0, 16'h0122, 0, 0, 0);
        add("call200",   1, 0, 0, 0, 16'h0000, 1, 16'h0200, 1, 0, 16'h0200, 1, 0, 0);
        add("prio_ret",  1, 0, 1, 1, 16'h0005, 1, 16'h0300, 1, 1, 16'h0123, 0, 0, 0);
        add("prio_jmp",  1, 0, 1, 1, 16'h0010, 1, 16'h0500, 0, 0, 16'h0500, 0, 0, 0);
        add("call_nojmp",1, 0, 1, 0, 16'h0000, 0, 16'h0999, 1, 0, 16'h0501, 0, 0, 0);
        add("jmpFFFF",   1, 0, 1, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 0);
        add("wrap_inc",  1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        add("br_pos",    1, 0, 1, 1, 16'h7FFF, 0, 16'h0000, 0, 0, 16'h8000, 0, 0, 0);
        add("br_wrap",   1, 0, 1, 1, 16'h8000, 0, 16'h0000, 0, 0, 16'h0001, 0, 0, 0);
        add("callAAA",   1, 0, 0, 0, 16'h0000, 1, 16'h0AAA, 1, 0, 16'h0AAA, 1, 0, 0);
        add("callBBB",   1, 0, 0, 0, 16'h0000, 1, 16'h0BBB, 1, 0, 16'h0BBB, 2, 0, 0);
        add("callCCC",   1, 0, 0, 0, 16'h0000, 1, 16'h0CCC, 1, 0, 16'h0CCC, 3, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst.pc", 32'(bus.pc), 32'h0010);
        check("rst.cnt", 32'(bus.ras_cnt), 32'h0);
        check("rst.ovf", 32'(bus.ras_ovf), 32'h0);
        check("rst.unf", 32'(bus.ras_unf), 32'h0);
        bus.if_en = 1'b1;
        #1;
        check("rst.iaddr_en", 32'(bus.inst_addr), 32'h0010);
        bus.if_en = 1'b0;
        #1;
        check("rst.iaddr_dis", 32'(bus.inst_addr), 32'h0);

        foreach (vecs[i]) apply(vecs[i]);

        // Async reset mid-cycle with a commit pending; PC must return before any edge
        bus.commit = 1'b1; bus.if_en = 1'b1; bus.jmp_en = 1'b1; bus.jmp_tgt = 16'h0DDD;
        bus.call = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst.pc", 32'(bus.pc), 32'h0010);
        check("arst.cnt", 32'(bus.ras_cnt), 32'h0);
        check("arst.iaddr", 32'(bus.inst_addr), 32'h0010);
        @(posedge clk);
        #1;
        check("arst.hold_pc", 32'(bus.pc), 32'h0010);
        rst = 1'b0;
        drive_idle();
        bus.commit = 1'b1; bus.ret = 1'b1;
        @(posedge clk);
        #1;
        check("arst.ret_unf", 32'(bus.ras_unf), 32'h1);
        check("arst.ret_pc", 32'(bus.pc), 32'h0011);
        check("arst.ret_cnt", 32'(bus.ras_cnt), 32'h0);
        drive_idle();
        @(posedge clk);
        #1;
        check("arst.unf_clear", 32'(bus.ras_unf), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
